// File: rtl/cap_bank_sequencer_pkg.sv
// Shared definitions for the capacitor-bank sequencer: default sizing,
// FSM state encodings and the FSM state type.
package cap_bank_sequencer_pkg;

    localparam int DEF_NBANK       = 4;
    localparam int DEF_DEAD_CYCLES = 8;
    localparam int DEF_STEP_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES = 64;
    localparam int DEF_CNT_W       = 8;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_BREAK  = 3'd1;
    localparam logic [2:0] ENC_DEAD   = 3'd2;
    localparam logic [2:0] ENC_MAKE   = 3'd3;
    localparam logic [2:0] ENC_SETTLE = 3'd4;
    localparam logic [2:0] ENC_HOLD   = 3'd5;
    localparam logic [2:0] ENC_FAULT  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_BREAK  = ENC_BREAK,
        ST_DEAD   = ENC_DEAD,
        ST_MAKE   = ENC_MAKE,
        ST_SETTLE = ENC_SETTLE,
        ST_HOLD   = ENC_HOLD,
        ST_FAULT  = ENC_FAULT
    } fsm_t;

endpackage

// File: rtl/cap_seq_timer.sv
// Loadable down-counter used for the dead, settle and hold intervals.
// Load wins over enable; the count stops at zero.
module cap_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load, else decrement while enabled and non-zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cap_bank_sequencer.sv
// Capacitor-bank sequencer: opens removed banks first, waits a dead time,
// closes added banks one per step with settle gaps, then holds off further
// changes for a minimum time. A level fault forces all banks open and
// latches until cleared with the fault input low.
module cap_bank_sequencer
    import cap_bank_sequencer_pkg::*;
#(
    parameter int NBANK       = DEF_NBANK,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk500kHz,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [NBANK-1:0] req_state,
    output logic             req_ready,
    input  logic             fault,
    input  logic             fault_clr,
    output logic [NBANK-1:0] state,
    output logic             busy,
    output logic             done,
    output logic             fault_latched,
    output logic [2:0]       dbg_fsm_o
);

    // Handshake: a request transfers on a posedge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, so a
    // requester must keep req_valid and req_state stable until then.

    fsm_t             fsm_q, fsm_d;
    logic [NBANK-1:0] state_q, state_d;
    logic [NBANK-1:0] target_q, target_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_zero;

    logic [NBANK-1:0] add_bits;
    logic [NBANK-1:0] low_bit;

    // Banks still to be closed, and the lowest-index one of them.
    assign add_bits = target_q & ~state_q;
    assign low_bit  = add_bits & (~add_bits + NBANK'(1));

    cap_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i     (clk500kHz),
        .rst_n_i   (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .en_i      (tmr_en),
        .zero_o    (tmr_zero)
    );

    // Next-state logic; a fault overrides every normal transition.
    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        target_d     = target_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        if (fault) begin
            fsm_d    = ST_FAULT;
            state_d  = '0;
            target_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        target_d = req_state;
                        if (req_state == state_q) begin
                            done_d = 1'b1;
                        end else if ((state_q & ~req_state) != '0) begin
                            fsm_d = ST_BREAK;
                        end else begin
                            fsm_d = ST_MAKE;
                        end
                    end
                end
                ST_BREAK: begin
                    state_d      = state_q & target_q;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(DEAD_CYCLES - 1);
                    fsm_d        = ST_DEAD;
                end
                ST_DEAD, ST_SETTLE: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (add_bits != '0) begin
                        fsm_d = ST_MAKE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(HOLD_CYCLES - 1);
                        fsm_d        = ST_HOLD;
                    end
                end
                ST_MAKE: begin
                    state_d      = state_q | low_bit;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(STEP_CYCLES - 1);
                    fsm_d        = ST_SETTLE;
                end
                ST_HOLD: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        fsm_d  = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fsm_d = ST_IDLE;
                    end
                end
                default: begin
                    fsm_d   = ST_IDLE;
                    state_d = '0;
                end
            endcase
        end
    end

    // State register; reset returns everything to the idle, all-open state.
    always_ff @(posedge clk500kHz) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    assign state         = state_q;
    assign done          = done_q;
    assign req_ready     = (fsm_q == ST_IDLE);
    assign busy          = (fsm_q != ST_IDLE) && (fsm_q != ST_FAULT);
    assign fault_latched = (fsm_q == ST_FAULT);
    assign dbg_fsm_o     = fsm_q;

endmodule
